module_b: RTL and testbench

Responder end of the A↔B word link. Accepts words that `module_a` drives on `data_to_b`, keeps an 8/N-bit running sum of them, and returns one response word per accepted word on `data_from_b`. Responses are buffered in a small FIFO so A can stall the return path without losing data. Sits opposite `module_a` in the same top-level wiring; all widths come from `config.vh`.

---
 rtl/module_b_pkg.sv | 27 ++
 rtl/b_resp_fifo.sv | 50 +++++
 rtl/module_b.sv | 73 +++++++
 tb/tb_module_b.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/module_b_pkg.sv
// module_b_pkg: shared widths for the A<->B link responder.
// Each value falls back to its default unless the top-level build defines
// the macro of the same name first.
`ifndef DATA_TO_B_BITWIDTH
`define DATA_TO_B_BITWIDTH 8
`endif
`ifndef DATA_FROM_B_BITWIDTH
`define DATA_FROM_B_BITWIDTH 8
`endif
`ifndef B_EXTRA_IN_BITWIDTH
`define B_EXTRA_IN_BITWIDTH 1
`endif
`ifndef B_EXTRA_OUT_BITWIDTH
`define B_EXTRA_OUT_BITWIDTH 3
`endif
`ifndef B_FIFO_DEPTH
`define B_FIFO_DEPTH 4
`endif

package module_b_pkg;
  localparam int DATA_TO_B_BITWIDTH   = `DATA_TO_B_BITWIDTH;
  localparam int DATA_FROM_B_BITWIDTH = `DATA_FROM_B_BITWIDTH;
  localparam int B_EXTRA_IN_BITWIDTH  = `B_EXTRA_IN_BITWIDTH;
  localparam int B_EXTRA_OUT_BITWIDTH = `B_EXTRA_OUT_BITWIDTH;
  localparam int B_FIFO_DEPTH         = `B_FIFO_DEPTH;
  localparam int B_FIFO_AW            = $clog2(B_FIFO_DEPTH);
endpackage

// File: rtl/b_resp_fifo.sv
// b_resp_fifo: response FIFO with wrap-bit pointers.
// Ports:
//   clk, rst_n        clock, async active-low reset (storage cleared too)
//   push, push_data   write tail (caller guarantees !full)
//   pop               advance head (caller guarantees !empty)
//   head_data         registered storage at the head index
//   count             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module b_resp_fifo
  import module_b_pkg::*;
#(
  parameter int WIDTH = DATA_FROM_B_BITWIDTH,
  parameter int DEPTH = B_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Same index with opposite wrap bits means the writer lapped the reader.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/module_b.sv
// module_b: responder end of the A<->B word link.
// Each accepted word is added into a running sum; the new sum is both kept
// and queued as the response word.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   data_to_b/_valid/_ready       word stream from A
//   data_from_b/_valid/_ready     response stream to A (FIFO head)
//   b_extra_in                    bit 0 clears the accumulator
//   b_extra_out                   FIFO occupancy, zero-extended
module module_b
  import module_b_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_TO_B_BITWIDTH-1:0]   data_to_b,
  input  logic                            data_to_b_valid,
  output logic                            data_to_b_ready,
  output logic [DATA_FROM_B_BITWIDTH-1:0] data_from_b,
  output logic                            data_from_b_valid,
  input  logic                            data_from_b_ready,
  input  logic [B_EXTRA_IN_BITWIDTH-1:0]  b_extra_in,
  output logic [B_EXTRA_OUT_BITWIDTH-1:0] b_extra_out
);
  logic [DATA_FROM_B_BITWIDTH-1:0] acc;
  logic [DATA_FROM_B_BITWIDTH-1:0] acc_base;
  logic [DATA_FROM_B_BITWIDTH-1:0] acc_next;
  logic [DATA_FROM_B_BITWIDTH-1:0] operand;
  logic                            clear;
  logic                            push;
  logic                            pop;
  logic [B_FIFO_AW:0]              fifo_count;
  logic                            fifo_full;
  logic                            fifo_empty;

  // Size cast zero-extends a narrower input and keeps LSBs of a wider one.
  assign operand  = DATA_FROM_B_BITWIDTH'(data_to_b);
  assign clear    = b_extra_in[0];
  assign acc_base = clear ? '0 : acc;
  assign acc_next = acc_base + operand;

  // Ready comes from registered state only, so a same-cycle pop does not
  // reopen a full FIFO.
  assign data_to_b_ready   = !fifo_full;
  assign data_from_b_valid = !fifo_empty;
  assign push              = data_to_b_valid && data_to_b_ready;
  assign pop               = data_from_b_valid && data_from_b_ready;
  assign b_extra_out       = B_EXTRA_OUT_BITWIDTH'(fifo_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (push) begin
      acc <= acc_next;
    end else if (clear) begin
      acc <= '0;
    end
  end

  b_resp_fifo #(
    .WIDTH(DATA_FROM_B_BITWIDTH),
    .DEPTH(B_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(acc_next),
    .pop      (pop),
    .head_data(data_from_b),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
endmodule

// File: tb/tb_module_b.sv
module tb_module_b;
  import module_b_pkg::*;

  logic                            clk;
  logic                            rst_n;
  logic [DATA_TO_B_BITWIDTH-1:0]   data_to_b;
  logic                            data_to_b_valid;
  logic                            data_to_b_ready;
  logic [DATA_FROM_B_BITWIDTH-1:0] data_from_b;
  logic                            data_from_b_valid;
  logic                            data_from_b_ready;
  logic [B_EXTRA_IN_BITWIDTH-1:0]  b_extra_in;
  logic [B_EXTRA_OUT_BITWIDTH-1:0] b_extra_out;

  int tests;
  int errors;

  module_b dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_to_b        (data_to_b),
    .data_to_b_valid  (data_to_b_valid),
    .data_to_b_ready  (data_to_b_ready),
    .data_from_b      (data_from_b),
    .data_from_b_valid(data_from_b_valid),
    .data_from_b_ready(data_from_b_ready),
    .b_extra_in       (b_extra_in),
    .b_extra_out      (b_extra_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic       clr;
    logic       pop_rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic push, input logic [7:0] din, input logic clr, input logic pop_rdy);
    data_to_b_valid   = push;
    data_to_b         = din;
    b_extra_in        = clr;
    data_from_b_ready = pop_rdy;
  endtask

  task automatic add(input logic p, input logic [7:0] d, input logic c, input logic r,
                     input logic ev, input logic [7:0] ed, input logic [2:0] ec, input logic er);
    vec_t v;
    v = '{p, d, c, r, ev, ed, ec, er};
    vecs.push_back(v);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Expected values are the state after the edge that consumed the inputs.
    //  push din  clr pop | valid data cnt rdy
    add(1, 8'h05, 0, 1,   1, 8'h05, 3'd1, 1);  // simple accumulate
    add(1, 8'h10, 0, 1,   1, 8'h15, 3'd1, 1);
    add(1, 8'h20, 0, 1,   1, 8'h35, 3'd1, 1);
    add(0, 8'h00, 0, 1,   0, 8'h00, 3'd0, 1);
    add(1, 8'h01, 1, 0,   1, 8'h01, 3'd1, 1);  // fill with ready held low
    add(1, 8'h01, 0, 0,   1, 8'h01, 3'd2, 1);
    add(1, 8'h01, 0, 0,   1, 8'h01, 3'd3, 1);
    add(1, 8'h01, 0, 0,   1, 8'h01, 3'd4, 0);
    add(1, 8'h01, 0, 1,   1, 8'h02, 3'd3, 1);  // pop while full: push refused
    add(1, 8'h01, 0, 0,   1, 8'h02, 3'd4, 0);  // 5th word now accepted
    add(0, 8'h00, 0, 1,   1, 8'h03, 3'd3, 1);
    add(0, 8'h00, 0, 1,   1, 8'h04, 3'd2, 1);
    add(0, 8'h00, 0, 1,   1, 8'h05, 3'd1, 1);
    add(0, 8'h00, 0, 1,   0, 8'h00, 3'd0, 1);
    add(1, 8'hF0, 1, 1,   1, 8'hF0, 3'd1, 1);  // wrap-around
    add(1, 8'h20, 0, 1,   1, 8'h10, 3'd1, 1);
    add(1, 8'hFF, 0, 1,   1, 8'h0F, 3'd1, 1);
    add(0, 8'h00, 0, 1,   0, 8'h00, 3'd0, 1);
    add(1, 8'h33, 1, 0,   1, 8'h33, 3'd1, 1);  // clear handling
    add(1, 8'h07, 1, 0,   1, 8'h33, 3'd2, 1);
    add(0, 8'h00, 1, 0,   1, 8'h33, 3'd2, 1);
    add(1, 8'h02, 0, 0,   1, 8'h33, 3'd3, 1);
    add(0, 8'h00, 0, 1,   1, 8'h07, 3'd2, 1);
    add(1, 8'h01, 0, 1,   1, 8'h02, 3'd2, 1);  // simultaneous push/pop
    add(0, 8'h00, 0, 1,   1, 8'h03, 3'd1, 1);
    add(0, 8'h00, 0, 1,   0, 8'h00, 3'd0, 1);

    #12;
    chk("reset valid", 32'(data_from_b_valid), 32'd0);
    chk("reset ready", 32'(data_to_b_ready), 32'd1);
    chk("reset count", 32'(b_extra_out), 32'd0);
    chk("reset data",  32'(data_from_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].push, vecs[i].din, vecs[i].clr, vecs[i].pop_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), 32'(data_from_b_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d count", i), 32'(b_extra_out), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d ready", i), 32'(data_to_b_ready), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d data", i), 32'(data_from_b), 32'(vecs[i].exp_data));
    end

    // Async reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      @(posedge clk);
    end
    #1;
    chk("pre-reset count", 32'(b_extra_out), 32'd3);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(data_from_b_valid), 32'd0);
    chk("async rst ready", 32'(data_to_b_ready), 32'd1);
    chk("async rst count", 32'(b_extra_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("post-rst valid", 32'(data_from_b_valid), 32'd1);
    chk("post-rst data",  32'(data_from_b), 32'h09);
    chk("post-rst count", 32'(b_extra_out), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
